// File: rtl/enc_pkg.sv
// Shared types and constants for the quadrature encoder input path
// (input filter and counter top).
package enc_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } enc_flt_state_e;

  localparam int unsigned FLT_LEN_MAX = 255;
  localparam int unsigned DIV_MAX     = 65535;
  localparam int unsigned FLT_LEN_DEF = 8;
  localparam int unsigned DIV_DEF     = 4;

endpackage

// File: rtl/enc_chan_integ.sv
// One encoder channel: 2-flop synchroniser, saturating integrator and hysteresis output.
// Glitch-event output is built only with ENC_INPUT_FLT_GLITCH_CNT_EN.
module enc_chan_integ
  import enc_pkg::*;
#(
  parameter int unsigned FLT_LEN = FLT_LEN_DEF
) (
  input  logic clock,
  input  logic aclr_n,
  input  logic clr_i,
  input  logic load_i,
  input  logic stb_i,
  input  logic raw_i,
  output logic out_o,
  output logic flip_o,
  output logic glitch_o
);

  localparam int unsigned CW = $clog2(FLT_LEN + 1);
  localparam logic [CW-1:0] FULL = CW'(FLT_LEN);

  logic [1:0]    sync_q;
  logic          sync_s;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_q, out_d;

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      out_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      cnt_q  <= cnt_d;
      out_q  <= out_d;
    end
  end

  assign sync_s = sync_q[1];

  // Clear leaves the output alone; it is only overwritten by the INIT reload.
  always_comb begin
    cnt_d = cnt_q;
    out_d = out_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = sync_s ? FULL : '0;
      out_d = sync_s;
    end else if (stb_i) begin
      if (sync_s && (cnt_q < FULL)) begin
        cnt_d = cnt_q + 1'b1;
      end else if (!sync_s && (cnt_q != '0)) begin
        cnt_d = cnt_q - 1'b1;
      end
      if (cnt_d == FULL) begin
        out_d = 1'b1;
      end else if (cnt_d == '0) begin
        out_d = 1'b0;
      end
    end
  end

  assign out_o  = out_q;
  assign flip_o = stb_i && !clr_i && !load_i && (out_d != out_q);

`ifdef ENC_INPUT_FLT_GLITCH_CNT_EN
  assign glitch_o = stb_i && !clr_i && !load_i &&
                    (( sync_s &&  out_q && (cnt_q < FULL)) ||
                     (!sync_s && !out_q && (cnt_q != '0)));
`else
  assign glitch_o = 1'b0;
`endif

endmodule

// File: rtl/enc_input_flt.sv
// Encoder A/B input conditioning: INIT/RUN FSM, sample prescaler, change strobe and
// sticky simultaneous-edge flag. Optional glitch counter: ENC_INPUT_FLT_GLITCH_CNT_EN.
module enc_input_flt
  import enc_pkg::*;
#(
  parameter int unsigned FLT_LEN = FLT_LEN_DEF,
  parameter int unsigned DIV     = DIV_DEF,
  parameter int unsigned GCNT_W  = 16
) (
  input  logic              clock,
  input  logic              aclr_n,
  input  logic              sclr,
  input  logic              ena,
  input  logic              A_in,
  input  logic              B_in,
  output logic              A,
  output logic              B,
  output logic              valid,
  output logic              changed,
  output logic              flt_err,
  output logic [GCNT_W-1:0] glitch_cnt
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  enc_flt_state_e state_q, state_d;
  logic [1:0]     wait_q, wait_d;
  logic [PW-1:0]  pre_q, pre_d;
  logic           valid_q, valid_d;
  logic           changed_q, changed_d;
  logic           err_q, err_d;
  logic           run_en, stb, load;
  logic           flip_a, flip_b, glitch_a, glitch_b;

  assign run_en = (state_q == RUN) && ena && !sclr;
  assign stb    = run_en && (pre_q == LAST);
  assign load   = (state_q == INIT) && (wait_q == 2'd2) && !sclr;

  enc_chan_integ #(.FLT_LEN(FLT_LEN)) u_chan_a (
    .clock(clock), .aclr_n(aclr_n), .clr_i(sclr), .load_i(load), .stb_i(stb),
    .raw_i(A_in), .out_o(A), .flip_o(flip_a), .glitch_o(glitch_a)
  );

  enc_chan_integ #(.FLT_LEN(FLT_LEN)) u_chan_b (
    .clock(clock), .aclr_n(aclr_n), .clr_i(sclr), .load_i(load), .stb_i(stb),
    .raw_i(B_in), .out_o(B), .flip_o(flip_b), .glitch_o(glitch_b)
  );

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q   <= INIT;
      wait_q    <= '0;
      pre_q     <= '0;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      pre_q     <= pre_d;
      valid_q   <= valid_d;
      changed_q <= changed_d;
      err_q     <= err_d;
    end
  end

  // The sclr edge counts as the first INIT clock (synchronisers are already full),
  // so the reload lands on the 3rd clock after both aclr_n release and sclr.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    pre_d     = pre_q;
    valid_d   = valid_q;
    changed_d = 1'b0;
    err_d     = err_q;
    if (sclr) begin
      state_d = INIT;
      wait_d  = 2'd1;
      pre_d   = '0;
      valid_d = 1'b0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          if (wait_q == 2'd2) begin
            state_d = RUN;
            valid_d = 1'b1;
            wait_d  = '0;
          end else begin
            wait_d = wait_q + 2'd1;
          end
        end
        RUN: begin
          if (ena) begin
            pre_d     = (pre_q == LAST) ? '0 : pre_q + 1'b1;
            changed_d = flip_a || flip_b;
            if (flip_a && flip_b) begin
              err_d = 1'b1;
            end
          end
        end
        default: state_d = INIT;
      endcase
    end
  end

  assign valid   = valid_q;
  assign changed = changed_q;
  assign flt_err = err_q;

`ifdef ENC_INPUT_FLT_GLITCH_CNT_EN
  logic [GCNT_W-1:0] gcnt_q, gcnt_d;
  logic [GCNT_W:0]   gsum;

  always_comb begin
    gsum   = {1'b0, gcnt_q} + {{GCNT_W{1'b0}}, glitch_a} + {{GCNT_W{1'b0}}, glitch_b};
    gcnt_d = gsum[GCNT_W] ? '1 : gsum[GCNT_W-1:0];
    if (sclr) begin
      gcnt_d = '0;
    end
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      gcnt_q <= '0;
    end else begin
      gcnt_q <= gcnt_d;
    end
  end

  assign glitch_cnt = gcnt_q;
`else
  logic unused_glitch;
  assign unused_glitch = glitch_a ^ glitch_b;
  assign glitch_cnt    = '0;
`endif

endmodule

// File: tb/tb_enc_input_flt.sv
// Self-checking bench for enc_input_flt: one DIV=1 and one DIV=4 instance (FLT_LEN=4)
// sharing stimulus; table-driven quadrature phases plus hand-written corner sequences.
module tb_enc_input_flt;

  logic        clock = 1'b0;
  logic        aclr_n, sclr, ena, A_in, B_in;
  logic        a1, b1, v1, c1, e1;
  logic        a4, b4, v4, c4, e4;
  logic [15:0] g1, g4;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  enc_input_flt #(.FLT_LEN(4), .DIV(1), .GCNT_W(16)) dut1 (
    .clock(clock), .aclr_n(aclr_n), .sclr(sclr), .ena(ena), .A_in(A_in), .B_in(B_in),
    .A(a1), .B(b1), .valid(v1), .changed(c1), .flt_err(e1), .glitch_cnt(g1)
  );

  enc_input_flt #(.FLT_LEN(4), .DIV(4), .GCNT_W(16)) dut4 (
    .clock(clock), .aclr_n(aclr_n), .sclr(sclr), .ena(ena), .A_in(A_in), .B_in(B_in),
    .A(a4), .B(b4), .valid(v4), .changed(c4), .flt_err(e4), .glitch_cnt(g4)
  );

`ifdef ENC_INPUT_FLT_GLITCH_CNT_EN
  localparam int EXP_GLITCH = 3;
`else
  localparam int EXP_GLITCH = 0;
`endif

  typedef struct {
    logic a;
    logic b;
    int   hold;
    logic ea;
    logic eb;
    int   echg;
    logic eerr;
  } vec_t;

  vec_t vecs[4];
  vec_t exp_q[$];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  initial begin
    int   chg_cnt;
    int   bad;
    int   total_chg;
    vec_t cur;

    vecs[0] = '{a: 1'b0, b: 1'b1, hold: 20, ea: 1'b0, eb: 1'b1, echg: 1, eerr: 1'b0};
    vecs[1] = '{a: 1'b1, b: 1'b1, hold: 20, ea: 1'b1, eb: 1'b1, echg: 1, eerr: 1'b0};
    vecs[2] = '{a: 1'b1, b: 1'b0, hold: 20, ea: 1'b1, eb: 1'b0, echg: 1, eerr: 1'b0};
    vecs[3] = '{a: 1'b0, b: 1'b0, hold: 20, ea: 1'b0, eb: 1'b0, echg: 1, eerr: 1'b0};

    aclr_n = 1'b0; sclr = 1'b0; ena = 1'b1; A_in = 1'b1; B_in = 1'b0;
    repeat (3) tick();
    chk("rst_A", a1, 0);
    chk("rst_valid", v1, 0);
    chk("rst_changed", c1, 0);
    chk("rst_flt_err", e1, 0);
    chk("rst_glitch", g1, 0);

    // Reset release: reload on the 3rd clock, no changed pulse
    aclr_n = 1'b1;
    tick(); chk("init_e1_valid", v1, 0);
    tick(); chk("init_e2_valid", v1, 0);
    tick();
    chk("init_e3_valid", v1, 1);
    chk("init_e3_valid4", v4, 1);
    chk("init_A", a1, 1);
    chk("init_B", b1, 0);
    chk("init_changed", c1, 0);
    chk_cnt: begin
      chg_cnt = 0;
      repeat (10) begin tick(); if (c1) chg_cnt++; end
      chk("init_no_changed", chg_cnt, 0);
    end

    // Clean rising step: visible at edge 6
    A_in = 1'b0;
    repeat (20) tick();
    chk("fall_A", a1, 0);
    A_in = 1'b1;
    repeat (5) tick();
    chk("step_e5_A", a1, 0);
    tick();
    chk("step_e6_A", a1, 1);
    chk("step_e6_changed", c1, 1);
    tick();
    chk("step_e7_changed", c1, 0);

    // Short pulse is rejected
    A_in = 1'b0;
    repeat (20) tick();
    chk("pre_pulse_A", a1, 0);
    chk("pre_pulse_glitch", g1, 0);
    bad = 0;
    A_in = 1'b1;
    repeat (3) begin tick(); if (a1 !== 1'b0 || c1 !== 1'b0) bad++; end
    A_in = 1'b0;
    repeat (10) begin tick(); if (a1 !== 1'b0 || c1 !== 1'b0) bad++; end
    chk("pulse_rejected", bad, 0);
    chk("pulse_glitch_cnt", g1, EXP_GLITCH);

    // Quadrature phases from the table
    total_chg = 0;
    for (int i = 0; i < 4; i++) begin
      A_in = vecs[i].a;
      B_in = vecs[i].b;
      exp_q.push_back(vecs[i]);
      chg_cnt = 0;
      repeat (vecs[i].hold) begin tick(); if (c1) chg_cnt++; end
      total_chg += chg_cnt;
      cur = exp_q.pop_front();
      chk($sformatf("quad%0d_A", i), a1, cur.ea);
      chk($sformatf("quad%0d_B", i), b1, cur.eb);
      chk($sformatf("quad%0d_changed", i), chg_cnt, cur.echg);
      chk($sformatf("quad%0d_flt_err", i), e1, cur.eerr);
    end
    chk("quad_total_changed", total_chg, 4);

    // Simultaneous flip sets the sticky error
    A_in = 1'b1; B_in = 1'b1;
    repeat (5) tick();
    chk("simul_e5_A", a1, 0);
    chk("simul_e5_B", b1, 0);
    tick();
    chk("simul_e6_A", a1, 1);
    chk("simul_e6_B", b1, 1);
    chk("simul_e6_changed", c1, 1);
    chk("simul_e6_flt_err", e1, 1);
    repeat (14) tick();
    A_in = 1'b0; B_in = 1'b0;
    repeat (20) tick();
    chk("simul_back_A", a1, 0);
    chk("simul_sticky_err", e1, 1);

    // sclr: INIT for 2 clocks, reload on the 3rd
    sclr = 1'b1;
    tick();
    sclr = 1'b0;
    chk("sclr_e1_valid", v1, 0);
    chk("sclr_e1_flt_err", e1, 0);
    chk("sclr_e1_valid4", v4, 0);
    tick();
    chk("sclr_e2_valid", v1, 0);
    tick();
    chk("sclr_e3_valid", v1, 1);
    chk("sclr_e3_A", a1, 0);
    chk("sclr_e3_changed", c1, 0);
    chk("sclr_e3_flt_err", e1, 0);
    chk("sclr_e3_A4", a4, 0);

    // DIV=4: step, freeze with ena=0 at cnt=2, resume
    A_in = 1'b1;
    repeat (8) tick();
    chk("div4_pre_freeze_A", a4, 0);
    ena = 1'b0;
    bad = 0;
    repeat (10) begin tick(); if (a4 !== 1'b0 || c4 !== 1'b0) bad++; end
    chk("div4_frozen", bad, 0);
    ena = 1'b1;
    repeat (7) tick();
    chk("div4_resume_e7_A", a4, 0);
    tick();
    chk("div4_resume_e8_A", a4, 1);
    chk("div4_resume_e8_changed", c4, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
